// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle for the bcd_to_bin converter.
// master = requester (drives start/bcd_in), slave = converter.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  bin_out, busy, done, err
  );

  modport slave (
    input  start, bcd_in,
    output bin_out, busy, done, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to unsigned-binary converter using
// reverse double-dabble (shift right, then digits >= 8 are reduced by 3).
// One conversion in flight; start/busy/done handshake through bcd_to_bin_if.
// Optional feature macro: BCD_TO_BIN_ERR_CHECK_EN
//   defined   -> digits > 9 are rejected at start with err=1, bin_out=0
//   undefined -> no validity check, err tied low, every start shifts
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic         clk,
  input  logic         rst,
  bcd_to_bin_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CTR_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BIN_W - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_DEC = pow10(DIGITS) - 1;

  // The result register must be able to hold the largest decimal value.
  generate
    if (BIN_W < 64 && ((64'd1 << BIN_W) <= MAX_DEC)) begin : g_width_check
      $error("bcd_to_bin: BIN_W too small for DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BIN_W-1:0]  bin_reg;
  logic [CTR_W-1:0]  ctr_reg;
  logic [BIN_W-1:0]  bin_out_reg;

  logic              load;
  logic              shift_en;
  logic              finish;
  logic              busy_c;
  logic              done_c;
  logic              input_ok;

  // One right shift of {bcd_reg, bin_reg}: a zero enters at the top and the
  // ones-digit LSB drops into the binary MSB.
  logic [BCD_W-1:0]  bcd_sh;
  logic [BIN_W-1:0]  bin_sh;
  logic [BCD_W-1:0]  bcd_fix;

  assign {bcd_sh, bin_sh} = {1'b0, bcd_reg, bin_reg[BIN_W-1:1]};

  // Per-digit correction after the shift; a digit >= 8 can only come from a
  // borrowed 10 (worth 8 after halving) so subtracting 3 never underflows.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_fix
      assign bcd_fix[4*gi +: 4] = (bcd_sh[4*gi +: 4] >= 4'd8)
                                  ? (bcd_sh[4*gi +: 4] - 4'd3)
                                  : bcd_sh[4*gi +: 4];
    end
  endgenerate

`ifdef BCD_TO_BIN_ERR_CHECK_EN
  logic [DIGITS-1:0] digit_bad;
  logic              err_reg;

  // Flag every incoming digit outside 0..9.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
      assign digit_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign input_ok = ~|digit_bad;

  // Error flag: set on a rejected start, cleared when a valid conversion ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (load && !input_ok) begin
      err_reg <= 1'b1;
    end else if (finish) begin
      err_reg <= 1'b0;
    end
  end

  assign bus.err = err_reg;
`else
  assign input_ok = 1'b1;
  assign bus.err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; DONE accepts a new start like IDLE.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = input_ok ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        busy_c   = 1'b1;
        shift_en = 1'b1;
        if (ctr_reg == CTR_LAST) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          load       = 1'b1;
          state_next = input_ok ? ST_SHIFT : ST_DONE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Working register, shift counter and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg     <= '0;
      bin_reg     <= '0;
      ctr_reg     <= '0;
      bin_out_reg <= '0;
    end else if (load) begin
      bcd_reg <= bus.bcd_in;
      bin_reg <= '0;
      ctr_reg <= '0;
      if (!input_ok) begin
        bin_out_reg <= '0;
      end
    end else if (shift_en) begin
      bcd_reg <= bcd_fix;
      bin_reg <= bin_sh;
      ctr_reg <= ctr_reg + 1'b1;
      if (finish) begin
        bin_out_reg <= bin_sh;
      end
    end
  end

  assign bus.bin_out = bin_out_reg;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus random values
// checked against a decimal reference model (plain integer arithmetic).
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal integer -> packed BCD.
  function automatic logic [15:0] dec_to_bcd(input int n);
    logic [15:0] b;
    int          v;
    b = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  // Issue one start and wait for done; lat = edges after the start edge.
  task automatic run_conversion(input logic [15:0] bcd, output int lat,
                                output int bcnt, output logic [13:0] res,
                                output logic e, output bit timed_out);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    tick();
    bus.start  = 1'b0;
    lat = -1; bcnt = 0; res = '0; e = 1'b0; timed_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k; res = bus.bin_out; e = bus.err; timed_out = 1'b0;
        break;
      end
      tick();
    end
    $display("[TB] conv bcd=%h bin=%0d err=%0b lat=%0d busy_cycles=%0d",
             bcd, res, e, lat, bcnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.bcd_in = '0;
    tick(); tick(); tick();
    tests_run++;
    if (bus.bin_out !== 14'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got bin=%0d busy=%b done=%b err=%b, expected all 0",
               bus.bin_out, bus.busy, bus.done, bus.err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, bcnt; logic [13:0] res; logic e; bit to;
    run_conversion(16'h0000, lat, bcnt, res, e, to);
    tests_run++;
    if (to || lat !== BIN_W) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d expected %0d", lat, BIN_W);
    end
    tests_run++;
    if (bcnt !== BIN_W) begin
      tests_failed++;
      $display("FAIL zero_busy_cycles: got %0d expected %0d", bcnt, BIN_W);
    end
    tests_run++;
    if (res !== 14'd0 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_result: got bin=%0d err=%b expected bin=0 err=0", res, e);
    end
    tick();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_pulse: done=%b one cycle later, expected 0", bus.done);
    end
  endtask

  task automatic test_fixed();
    logic [15:0] vec_bcd [3] = '{16'h9999, 16'h0255, 16'h1000};
    int          vec_exp [3] = '{9999, 255, 1000};
    int lat, bcnt; logic [13:0] res; logic e; bit to;
    for (int i = 0; i < 3; i++) begin
      run_conversion(vec_bcd[i], lat, bcnt, res, e, to);
      tests_run++;
      if (to || lat !== BIN_W || res !== 14'(vec_exp[i]) || e !== 1'b0) begin
        tests_failed++;
        $display("FAIL fixed_%0d: got bin=%0d err=%b lat=%0d expected bin=%0d err=0 lat=%0d",
                 i, res, e, lat, vec_exp[i], BIN_W);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, dones; logic [13:0] res; logic e; bit to;
    bus.start = 1'b1; bus.bcd_in = 16'h4321;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_busy: got busy=%b expected 1 before reset", bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.bin_out !== 14'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got bin=%0d busy=%b done=%b err=%b expected all 0",
               bus.bin_out, bus.busy, bus.done, bus.err);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      tick();
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
    end
    run_conversion(16'h0042, lat, bcnt, res, e, to);
    tests_run++;
    if (to || lat !== BIN_W || res !== 14'd42) begin
      tests_failed++;
      $display("FAIL reset_mid_next: got bin=%0d lat=%0d expected bin=42 lat=%0d", res, lat, BIN_W);
    end
  endtask

  task automatic test_invalid();
    int lat, bcnt; logic [13:0] res; logic e; bit to;
    run_conversion(16'h12A4, lat, bcnt, res, e, to);
`ifdef BCD_TO_BIN_ERR_CHECK_EN
    tests_run++;
    if (to || lat !== 0 || bcnt !== 0) begin
      tests_failed++;
      $display("FAIL invalid_latency: got lat=%0d busy_cycles=%0d expected 0 and 0", lat, bcnt);
    end
    tests_run++;
    if (res !== 14'd0 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL invalid_result: got bin=%0d err=%b expected bin=0 err=1", res, e);
    end
`else
    tests_run++;
    if (to || lat !== BIN_W || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_nocheck: got lat=%0d err=%b expected lat=%0d err=0", lat, e, BIN_W);
    end
`endif
    tick();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_done_pulse: done=%b one cycle later, expected 0", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [13:0] res;
    bus.start = 1'b1; bus.bcd_in = 16'h0007;
    tick();
    bus.bcd_in = 16'h0008;       // start stays high through SHIFT and DONE
    lat = -1; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin lat = k; res = bus.bin_out; break; end
      tick();
    end
    $display("[TB] conv bcd=0007 bin=%0d lat=%0d (start held)", res, lat);
    tests_run++;
    if (lat !== BIN_W || res !== 14'd7) begin
      tests_failed++;
      $display("FAIL b2b_first: got bin=%0d lat=%0d expected bin=7 lat=%0d", res, lat, BIN_W);
    end
    tick();                      // DONE edge accepts 0008
    bus.start = 1'b0;
    lat = -1; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin lat = k; res = bus.bin_out; break; end
      tick();
    end
    $display("[TB] conv bcd=0008 bin=%0d lat=%0d (back-to-back)", res, lat);
    tests_run++;
    if (lat !== BIN_W || res !== 14'd8) begin
      tests_failed++;
      $display("FAIL b2b_second: got bin=%0d lat=%0d expected bin=8 lat=%0d", res, lat, BIN_W);
    end
    tick();
  endtask

  task automatic test_start_during_shift();
    int lat; logic [13:0] res;
    bus.start = 1'b1; bus.bcd_in = 16'h0255;
    tick();
    bus.start = 1'b0;
    lat = -1; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin lat = k; res = bus.bin_out; break; end
      bus.start  = (k == 5);
      if (k == 5) bus.bcd_in = 16'h0999;
      tick();
    end
    bus.start = 1'b0;
    $display("[TB] conv bcd=0255 bin=%0d lat=%0d (start pulsed mid-shift)", res, lat);
    tests_run++;
    if (lat !== BIN_W || res !== 14'd255) begin
      tests_failed++;
      $display("FAIL shift_ignores_start: got bin=%0d lat=%0d expected bin=255 lat=%0d",
               res, lat, BIN_W);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bcnt, n, exp_lat, exp_val; logic [13:0] res; logic e; bit to, bad;
    logic [15:0] bcd;
    for (int i = 0; i < 24; i++) begin
      n   = int'($urandom_range(0, 9999));
      bcd = dec_to_bcd(n);
      bad = 1'b0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
      if (i % 4 == 3) begin
        bcd[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        bad = 1'b1;
      end
`endif
      exp_lat = bad ? 0 : BIN_W;
      exp_val = bad ? 0 : n;
      run_conversion(bcd, lat, bcnt, res, e, to);
      tests_run++;
      if (to || lat !== exp_lat || res !== 14'(exp_val) || e !== bad) begin
        tests_failed++;
        $display("FAIL random_%0d bcd=%h: got bin=%0d err=%b lat=%0d expected bin=%0d err=%b lat=%0d",
                 i, bcd, res, e, lat, exp_val, bad, exp_lat);
      end
      if (i % 2 == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fixed();
    test_reset_mid();
    test_invalid();
    test_back_to_back();
    test_start_during_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
